edge_layer_mem: RTL and testbench

//  Responder side of the edge-detection engine's layer-memory interface (cwr/caddr_wr/cdata_wr, crd/caddr_rd_1..9/cdata_rd_1..9, csel).

---
 rtl/edge_layer_mem_pkg.sv | 12 +
 rtl/edge_layer_mem_bank.sv | 28 ++
 rtl/edge_layer_mem.sv | 136 +++++++++++++
 tb/tb_edge_layer_mem.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/edge_layer_mem_pkg.sv
// edge_layer_mem_pkg: bank-select codes and dump FSM state encodings shared by the layer-memory block
package edge_layer_mem_pkg;

    localparam logic [2:0] CSEL_L1 = 3'b001;
    localparam logic [2:0] CSEL_L2 = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DUMP  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/edge_layer_mem_bank.sv
// edge_layer_mem_bank: DEPTH x DATA_W frame array, one synchronous write port, NRD asynchronous read ports
//   clk         in   clock
//   we/waddr/wdata  in   write port, applied on the rising edge
//   raddr[NRD]  in   read addresses
//   rdata[NRD]  out  read data, combinational (returns pre-write contents in a write cycle)
// Contents are deliberately not reset.
module edge_layer_mem_bank #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int NRD    = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr [NRD],
    output logic [DATA_W-1:0] rdata [NRD]
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_comb
        for (int i = 0; i < NRD; i++) rdata[i] = mem[raddr[i]];

endmodule

// File: rtl/edge_layer_mem.sv
// edge_layer_mem: layer-memory responder with L1/L2 frame banks, nine read taps and a host dump port
//   clk, reset_n            clock, asynchronous active-low reset
//   csel/cwr/caddr_wr/cdata_wr   write port; csel 001 = L1, 010 = L2, anything else flags sel_err
//   crd, caddr_rd_1..9, cdata_rd_1..9   combinational L1 read taps (0 when crd low)
//   busy                    engine busy; high then low starts a dump
//   dump_valid/dump_ready/dump_addr/dump_data/dump_done   valid/ready frame stream to the host
//   sel_err                 sticky illegal-select write flag
// Macro DUMP_L1_EN: dump streams L1 then L2 and adds the dump_bank output.
module edge_layer_mem
    import edge_layer_mem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        csel,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd_1,
    input  logic [ADDR_W-1:0] caddr_rd_2,
    input  logic [ADDR_W-1:0] caddr_rd_3,
    input  logic [ADDR_W-1:0] caddr_rd_4,
    input  logic [ADDR_W-1:0] caddr_rd_5,
    input  logic [ADDR_W-1:0] caddr_rd_6,
    input  logic [ADDR_W-1:0] caddr_rd_7,
    input  logic [ADDR_W-1:0] caddr_rd_8,
    input  logic [ADDR_W-1:0] caddr_rd_9,
    output logic [DATA_W-1:0] cdata_rd_1,
    output logic [DATA_W-1:0] cdata_rd_2,
    output logic [DATA_W-1:0] cdata_rd_3,
    output logic [DATA_W-1:0] cdata_rd_4,
    output logic [DATA_W-1:0] cdata_rd_5,
    output logic [DATA_W-1:0] cdata_rd_6,
    output logic [DATA_W-1:0] cdata_rd_7,
    output logic [DATA_W-1:0] cdata_rd_8,
    output logic [DATA_W-1:0] cdata_rd_9,
    input  logic              busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done,
`ifdef DUMP_L1_EN
    output logic              dump_bank,
`endif
    output logic              sel_err
);

`ifdef DUMP_L1_EN
    localparam int NRD1 = 10;
`else
    localparam int NRD1 = 9;
`endif

    logic              rd_en, l1_we, l2_we, accept, last;
    logic [1:0]        state;
    logic [ADDR_W-1:0] l1_raddr [NRD1];
    logic [DATA_W-1:0] l1_rdata [NRD1];
    logic [ADDR_W-1:0] l2_raddr [1];
    logic [DATA_W-1:0] l2_rdata [1];

    // Taps read as zero while reset is asserted, as if crd were low.
    assign rd_en = crd & reset_n;
    assign l1_we = cwr && csel == CSEL_L1;
    assign l2_we = cwr && csel == CSEL_L2;

    assign l1_raddr[0] = caddr_rd_1;
    assign l1_raddr[1] = caddr_rd_2;
    assign l1_raddr[2] = caddr_rd_3;
    assign l1_raddr[3] = caddr_rd_4;
    assign l1_raddr[4] = caddr_rd_5;
    assign l1_raddr[5] = caddr_rd_6;
    assign l1_raddr[6] = caddr_rd_7;
    assign l1_raddr[7] = caddr_rd_8;
    assign l1_raddr[8] = caddr_rd_9;
    assign l2_raddr[0] = dump_addr;

    assign cdata_rd_1 = rd_en ? l1_rdata[0] : '0;
    assign cdata_rd_2 = rd_en ? l1_rdata[1] : '0;
    assign cdata_rd_3 = rd_en ? l1_rdata[2] : '0;
    assign cdata_rd_4 = rd_en ? l1_rdata[3] : '0;
    assign cdata_rd_5 = rd_en ? l1_rdata[4] : '0;
    assign cdata_rd_6 = rd_en ? l1_rdata[5] : '0;
    assign cdata_rd_7 = rd_en ? l1_rdata[6] : '0;
    assign cdata_rd_8 = rd_en ? l1_rdata[7] : '0;
    assign cdata_rd_9 = rd_en ? l1_rdata[8] : '0;

    edge_layer_mem_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NRD(NRD1)) u_l1 (
        .clk(clk), .we(l1_we), .waddr(caddr_wr), .wdata(cdata_wr),
        .raddr(l1_raddr), .rdata(l1_rdata)
    );

    edge_layer_mem_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NRD(1)) u_l2 (
        .clk(clk), .we(l2_we), .waddr(caddr_wr), .wdata(cdata_wr),
        .raddr(l2_raddr), .rdata(l2_rdata)
    );

    assign dump_valid = state == ST_DUMP;
    assign dump_done  = state == ST_DONE;
    assign accept     = dump_valid & dump_ready;

`ifdef DUMP_L1_EN
    // The extra L1 port is the dump's view of L1; the counter runs over L1 first, then L2.
    assign l1_raddr[9] = dump_addr;
    assign dump_data   = dump_bank ? l2_rdata[0] : l1_rdata[9];
    assign last        = dump_bank && dump_addr == '1;
`else
    assign dump_data   = l2_rdata[0];
    assign last        = dump_addr == '1;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= ST_IDLE;
            dump_addr <= '0;
            sel_err   <= 1'b0;
`ifdef DUMP_L1_EN
            dump_bank <= 1'b0;
`endif
        end else begin
            if (cwr && !l1_we && !l2_we) sel_err <= 1'b1;
            if (state == ST_IDLE && busy) state <= ST_ARMED;
            else if (state == ST_ARMED && !busy) state <= ST_DUMP;
            else if (accept && last) state <= ST_DONE;
            else if (state == ST_DONE) state <= ST_IDLE;
            // The counter rolls back to zero on the final beat, ready for the next dump.
            if (accept) dump_addr <= dump_addr + 1'b1;
`ifdef DUMP_L1_EN
            if (accept && dump_addr == '1) dump_bank <= ~dump_bank;
`endif
        end

endmodule

// File: tb/tb_edge_layer_mem.sv
// tb_edge_layer_mem: directed self-checking bench for edge_layer_mem (default L2-only dump build)
module tb_edge_layer_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  csel;
    logic        cwr, crd, busy, dump_ready;
    logic [11:0] caddr_wr;
    logic [7:0]  cdata_wr;
    logic [11:0] ra [9];
    logic [7:0]  rd [9];
    logic        dump_valid, dump_done, sel_err;
    logic [11:0] dump_addr;
    logic [7:0]  dump_data;

    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    edge_layer_mem dut (
        .clk(clk), .reset_n(reset_n), .csel(csel), .cwr(cwr),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
        .caddr_rd_1(ra[0]), .caddr_rd_2(ra[1]), .caddr_rd_3(ra[2]),
        .caddr_rd_4(ra[3]), .caddr_rd_5(ra[4]), .caddr_rd_6(ra[5]),
        .caddr_rd_7(ra[6]), .caddr_rd_8(ra[7]), .caddr_rd_9(ra[8]),
        .cdata_rd_1(rd[0]), .cdata_rd_2(rd[1]), .cdata_rd_3(rd[2]),
        .cdata_rd_4(rd[3]), .cdata_rd_5(rd[4]), .cdata_rd_6(rd[5]),
        .cdata_rd_7(rd[6]), .cdata_rd_8(rd[7]), .cdata_rd_9(rd[8]),
        .busy(busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done),
        .sel_err(sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] s, input logic [11:0] a, input logic [7:0] d);
        csel = s; caddr_wr = a; cdata_wr = d; cwr = 1'b1;
        tick();
        cwr = 1'b0; csel = 3'b000;
    endtask

    initial begin
        int beats, cyc, bad_order, bad_hold, bad_valid, done_seen;
        logic held;
        logic [11:0] p_addr;
        logic [7:0]  p_data;
        reset_n = 1'b0; csel = 3'b000; cwr = 1'b0; crd = 1'b1; busy = 1'b0;
        dump_ready = 1'b0; caddr_wr = '0; cdata_wr = '0;
        for (int i = 0; i < 9; i++) ra[i] = 12'h041;
        #12;
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_addr", dump_addr, 0);
        chk("rst_dump_done", dump_done, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_tap5", rd[4], 0);
        reset_n = 1'b1;
        crd = 1'b0;
        tick();

        // L1 write then same-cycle-visible tap read
        wr(3'b001, 12'h041, 8'h5A);
        crd = 1'b1; #1;
        chk("tap5_after_write", rd[4], 8'h5A);
        chk("tap1_after_write", rd[0], 8'h5A);
        crd = 1'b0; #1;
        for (int i = 0; i < 9; i++) chk($sformatf("tap%0d_crd0", i + 1), rd[i], 0);

        // read-during-write returns old data
        crd = 1'b1; csel = 3'b001; cwr = 1'b1; caddr_wr = 12'h041; cdata_wr = 8'h77; #1;
        chk("rdw_old", rd[4], 8'h5A);
        tick();
        cwr = 1'b0; csel = 3'b000; #1;
        chk("rdw_new", rd[4], 8'h77);

        // L2 writes must not touch L1
        wr(3'b001, 12'h000, 8'h00);
        wr(3'b010, 12'h000, 8'hFF);
        wr(3'b010, 12'h041, 8'h22);
        wr(3'b010, 12'd100, 8'h64);
        wr(3'b010, 12'hFFF, 8'h3C);
        ra[0] = 12'h000; #1;
        chk("l1_0_after_l2_wr", rd[0], 8'h00);
        chk("l1_41_after_l2_wr", rd[8], 8'h77);
        chk("sel_err_legal", sel_err, 0);

        // illegal selects
        wr(3'b000, 12'h041, 8'h11);
        chk("sel_err_000", sel_err, 1);
        wr(3'b011, 12'h041, 8'h12);
        wr(3'b001, 12'h001, 8'h01);
        tick(); tick();
        chk("sel_err_sticky", sel_err, 1);
        chk("l1_41_after_bad", rd[8], 8'h77);

        // dump with random ready
        busy = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("armed_no_valid", dump_valid, 0);
        busy = 1'b0;
        tick();
        chk("dump_start_valid", dump_valid, 1);
        chk("dump_start_addr", dump_addr, 0);
        beats = 0; cyc = 0; bad_order = 0; bad_hold = 0; bad_valid = 0; done_seen = 0;
        held = 1'b0; p_addr = '0; p_data = '0;
        while (beats < 4096 && cyc < 20000) begin
            dump_ready = 1'($urandom_range(0, 1));
            if (cyc == 0) begin csel = 3'b010; cwr = 1'b1; caddr_wr = 12'd2000; cdata_wr = 8'hAB; end
            if (cyc == 1) begin cwr = 1'b0; csel = 3'b000; end
            #1;
            if (dump_done) done_seen++;
            if (!dump_valid) bad_valid++;
            if (dump_addr !== 12'(beats)) bad_order++;
            if (held && (dump_addr !== p_addr || dump_data !== p_data)) bad_hold++;
            if (dump_ready) begin
                if (beats == 0)    chk("dump_data_0", dump_data, 8'hFF);
                if (beats == 'h41) chk("dump_data_41", dump_data, 8'h22);
                if (beats == 100)  chk("dump_data_100", dump_data, 8'h64);
                if (beats == 2000) chk("dump_data_2000", dump_data, 8'hAB);
                if (beats == 4095) chk("dump_data_4095", dump_data, 8'h3C);
                beats++;
            end
            held = !dump_ready; p_addr = dump_addr; p_data = dump_data;
            tick();
            cyc++;
        end
        chk("dump_beats", beats, 4096);
        chk("dump_order_errs", bad_order, 0);
        chk("dump_hold_errs", bad_hold, 0);
        chk("dump_valid_errs", bad_valid, 0);
        chk("dump_done_early", done_seen, 0);
        dump_ready = 1'b0; #1;
        chk("done_pulse", dump_done, 1);
        chk("done_valid_low", dump_valid, 0);
        tick();
        chk("done_one_cycle", dump_done, 0);
        chk("idle_valid_low", dump_valid, 0);
        chk("idle_addr_zero", dump_addr, 0);

        // reset in the middle of a dump
        busy = 1'b1; tick(); tick(); tick();
        busy = 1'b0; tick();
        dump_ready = 1'b1;
        cyc = 0;
        while (dump_addr != 12'd100 && cyc < 500) begin tick(); cyc++; end
        chk("mid_dump_addr100", dump_addr, 100);
        #2 reset_n = 1'b0; #1;
        chk("mid_rst_valid", dump_valid, 0);
        chk("mid_rst_addr", dump_addr, 0);
        chk("mid_rst_done", dump_done, 0);
        chk("mid_rst_sel_err", sel_err, 0);
        chk("mid_rst_tap", rd[8], 0);
        tick();
        reset_n = 1'b1;
        bad_valid = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (dump_valid) bad_valid++; end
        chk("no_beats_after_rst", bad_valid, 0);
        chk("l1_kept_after_rst", rd[8], 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
